// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with branch/jump/return/exception redirect
// and a circular return-address stack.
module pc_sequencer #(
    parameter int unsigned          WIDTH     = 32,
    parameter int unsigned          INC       = 4,
    parameter logic [WIDTH-1:0]     RESET_VEC = '0,
    parameter logic [WIDTH-1:0]     EXC_VEC   = WIDTH'('h80),
    parameter int unsigned          RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             exc_req,
    input  logic             ret_req,
    input  logic             jmp_req,
    input  logic             jmp_link,
    input  logic [WIDTH-1:0] jmp_target,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_offset,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf,
    output logic             ras_udf
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [WIDTH-1:0] MASK = ~(WIDTH'(INC) - WIDTH'(1));
    localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]    ptr;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] pc_n;
    logic [PW-1:0]    ptr_n;
    logic [CW-1:0]    cnt_n;
    logic             ovf_n;
    logic             udf_n;
    logic             push;

    assign pc_plus   = pc_out + WIDTH'(INC);
    assign ras_empty = (cnt == '0);
    assign ras_full  = (cnt == FULL_CNT);

    // Priority chain: exception beats stall, stall swallows ret/jmp/br.
    always_comb begin
        pc_n  = pc_out;
        ptr_n = ptr;
        cnt_n = cnt;
        ovf_n = ras_ovf;
        udf_n = ras_udf;
        push  = 1'b0;
        if (exc_req) begin
            pc_n = EXC_VEC;
        end else if (stall) begin
            pc_n = pc_out;
        end else if (ret_req) begin
            if (!ras_empty) begin
                pc_n  = ras[ptr];
                ptr_n = ptr - 1'b1;
                cnt_n = cnt - 1'b1;
            end else begin
                pc_n  = pc_plus;
                udf_n = 1'b1;
            end
        end else if (jmp_req) begin
            pc_n = jmp_target;
            if (jmp_link) begin
                push  = 1'b1;
                ptr_n = ptr + 1'b1;
                if (ras_full) begin
                    ovf_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
        end else if (br_taken) begin
            pc_n = pc_out + br_offset;
        end else begin
            pc_n = pc_plus;
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            pc_out  <= RESET_VEC & MASK;
            ptr     <= '0;
            cnt     <= '0;
            ras_ovf <= 1'b0;
            ras_udf <= 1'b0;
        end else begin
            pc_out  <= pc_n & MASK;
            ptr     <= ptr_n;
            cnt     <= cnt_n;
            ras_ovf <= ovf_n;
            ras_udf <= udf_n;
        end
    end

    // When full, ptr+1 lands on the oldest entry, giving circular overwrite.
    always_ff @(negedge clk) begin
        if (!rst && push) begin
            ras[ptr_n] <= pc_plus;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer.
// State changes on the falling clock edge; outputs are checked 1ns later.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        exc_req;
    logic        ret_req;
    logic        jmp_req;
    logic        jmp_link;
    logic [31:0] jmp_target;
    logic        br_taken;
    logic [31:0] br_offset;
    logic [31:0] pc_out;
    logic [31:0] pc_plus;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_ovf;
    logic        ras_udf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .exc_req    (exc_req),
        .ret_req    (ret_req),
        .jmp_req    (jmp_req),
        .jmp_link   (jmp_link),
        .jmp_target (jmp_target),
        .br_taken   (br_taken),
        .br_offset  (br_offset),
        .pc_out     (pc_out),
        .pc_plus    (pc_plus),
        .ras_empty  (ras_empty),
        .ras_full   (ras_full),
        .ras_ovf    (ras_ovf),
        .ras_udf    (ras_udf)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr();
        rst        = 1'b0;
        stall      = 1'b0;
        exc_req    = 1'b0;
        ret_req    = 1'b0;
        jmp_req    = 1'b0;
        jmp_link   = 1'b0;
        jmp_target = '0;
        br_taken   = 1'b0;
        br_offset  = '0;
    endtask

    task automatic edge_step();
        @(negedge clk);
        #1;
        clr();
    endtask

    task automatic idle();
        edge_step();
    endtask

    task automatic jmp(input logic [31:0] t, input logic link);
        jmp_req    = 1'b1;
        jmp_link   = link;
        jmp_target = t;
        edge_step();
    endtask

    task automatic ret();
        ret_req = 1'b1;
        edge_step();
    endtask

    task automatic br(input logic [31:0] off);
        br_taken  = 1'b1;
        br_offset = off;
        edge_step();
    endtask

    task automatic do_rst();
        rst = 1'b1;
        edge_step();
    endtask

    initial begin
        clr();
        #2;

        // 1: reset and sequential fetch
        do_rst();
        check("rst_pc", pc_out, 32'h0);
        check("rst_plus", pc_plus, 32'h4);
        check("rst_empty", ras_empty, 1);
        check("rst_full", ras_full, 0);
        check("rst_ovf", ras_ovf, 0);
        check("rst_udf", ras_udf, 0);
        idle();
        check("seq1", pc_out, 32'h4);
        idle();
        check("seq2", pc_out, 32'h8);
        idle();
        check("seq3", pc_out, 32'hC);
        check("seq3_plus", pc_plus, 32'h10);

        // 2: call and return
        jmp(32'h10, 1'b0);
        check("jmp10", pc_out, 32'h10);
        jmp(32'h200, 1'b1);
        check("call_pc", pc_out, 32'h200);
        check("call_nempty", ras_empty, 0);
        ret();
        check("ret_pc", pc_out, 32'h14);
        check("ret_empty", ras_empty, 1);

        // 3: nested calls past depth, then unwind past empty
        jmp(32'h0, 1'b0);
        jmp(32'h100, 1'b1);
        jmp(32'h200, 1'b1);
        jmp(32'h300, 1'b1);
        jmp(32'h400, 1'b1);
        check("c4_full", ras_full, 1);
        check("c4_ovf", ras_ovf, 0);
        jmp(32'h500, 1'b1);
        check("c5_pc", pc_out, 32'h500);
        check("c5_full", ras_full, 1);
        check("c5_ovf", ras_ovf, 1);
        ret();
        check("r1", pc_out, 32'h404);
        check("r1_full", ras_full, 0);
        ret();
        check("r2", pc_out, 32'h304);
        ret();
        check("r3", pc_out, 32'h204);
        ret();
        check("r4", pc_out, 32'h104);
        check("r4_empty", ras_empty, 1);
        check("r4_udf", ras_udf, 0);
        ret();
        check("r5_pc", pc_out, 32'h108);
        check("r5_udf", ras_udf, 1);
        check("r5_empty", ras_empty, 1);

        // 4: branch, wrap, alignment
        jmp(32'h100, 1'b0);
        br(32'hFFFF_FFF8);
        check("br_neg", pc_out, 32'hF8);
        br(32'h20);
        check("br_pos", pc_out, 32'h118);
        jmp(32'hFFFF_FFFC, 1'b0);
        check("plus_wrap", pc_plus, 32'h0);
        idle();
        check("seq_wrap", pc_out, 32'h0);
        jmp(32'h203, 1'b0);
        check("jmp_align", pc_out, 32'h200);
        br(32'h7);
        check("br_align", pc_out, 32'h204);
        check("ovf_sticky", ras_ovf, 1);
        check("udf_sticky", ras_udf, 1);

        // 6: reset wins over a simultaneous call
        rst        = 1'b1;
        jmp_req    = 1'b1;
        jmp_link   = 1'b1;
        jmp_target = 32'h500;
        edge_step();
        check("rc_pc", pc_out, 32'h0);
        check("rc_empty", ras_empty, 1);
        check("rc_ovf", ras_ovf, 0);
        check("rc_udf", ras_udf, 0);
        ret();
        check("rc_ret_pc", pc_out, 32'h4);
        check("rc_ret_udf", ras_udf, 1);

        // 5: stall and exception
        do_rst();
        jmp(32'h10, 1'b0);
        jmp(32'h300, 1'b1);
        stall   = 1'b1;
        ret_req = 1'b1;
        edge_step();
        check("st_ret_pc", pc_out, 32'h300);
        check("st_ret_nempty", ras_empty, 0);
        stall    = 1'b1;
        jmp_req  = 1'b1;
        jmp_link = 1'b1;
        jmp_target = 32'h700;
        edge_step();
        check("st_jmp_pc", pc_out, 32'h300);
        stall   = 1'b1;
        exc_req = 1'b1;
        edge_step();
        check("st_exc_pc", pc_out, 32'h80);
        check("st_exc_nempty", ras_empty, 0);
        exc_req = 1'b1;
        ret_req = 1'b1;
        edge_step();
        check("exc_ret_pc", pc_out, 32'h80);
        ret();
        check("post_ret_pc", pc_out, 32'h14);
        check("post_ret_empty", ras_empty, 1);
        check("post_udf", ras_udf, 0);
        check("post_ovf", ras_ovf, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
